// File: rtl/card_draw_arbiter.sv
// -----------------------------------------------------------------------------
// card_draw_arbiter
//
// Deals cards from a single deck to two requesters (player and dealer). A
// round-robin arbiter picks the requester, a random value is fetched and
// reduced into the deck range, and dealt cards are skipped by linear probing
// until a free card is found. Rank and suit are decoded on delivery.
//
// Ports
//   clk          - clock, rising edge
//   reset        - synchronous active-high reset
//   player_req   - player level request for one card
//   dealer_req   - dealer level request for one card
//   shuffle      - return all cards to the deck (honoured in IDLE only)
//   rand_value   - random value, sampled while rand_request is high
//   rand_request - one-cycle random value request (FETCH state)
//   grant_player - player is being served
//   grant_dealer - dealer is being served
//   card_valid   - one-cycle card delivery strobe
//   card_index   - dealt card, 0..DECK_SIZE-1
//   card_rank    - card rank, 1..13 (1 = ace)
//   card_suit    - card suit, 0..3
//   deck_empty   - all DECK_SIZE cards have been dealt
//   busy         - a transaction is in progress (state is not IDLE)
// -----------------------------------------------------------------------------
module card_draw_arbiter #(
   parameter int DECK_SIZE = 52,
   parameter int IDX_W     = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             player_req,
   input  logic             dealer_req,
   input  logic             shuffle,
   input  logic [IDX_W-1:0] rand_value,
   output logic             rand_request,
   output logic             grant_player,
   output logic             grant_dealer,
   output logic             card_valid,
   output logic [IDX_W-1:0] card_index,
   output logic [3:0]       card_rank,
   output logic [1:0]       card_suit,
   output logic             deck_empty,
   output logic             busy
);

   localparam int CNT_W = $clog2(DECK_SIZE + 1);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      CHECK,
      DELIVER
   } state_t;

   state_t               state;
   state_t               next_state;
   logic [IDX_W-1:0]     cand;
   logic [IDX_W-1:0]     cand_eff;
   logic [IDX_W-1:0]     cand_next;
   logic [DECK_SIZE-1:0] dealt;
   logic [CNT_W-1:0]     dealt_cnt;
   logic                 last_player;   // 1: player was served most recently
   logic                 win_player;
   logic                 win_dealer;
   logic                 do_shuffle;
   logic                 hit;

   assign deck_empty   = (dealt_cnt == CNT_W'(DECK_SIZE));
   assign busy         = (state != IDLE);
   assign rand_request = (state == FETCH);

   // NOTE: every signal written here gets a default first so no path leaves it
   // unassigned; otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      next_state = state;
      win_player = 1'b0;
      win_dealer = 1'b0;
      do_shuffle = 1'b0;
      // A raw random value is at most 2*DECK_SIZE-1 for the default sizing, so
      // a single conditional subtract brings it into range. After the first
      // CHECK cycle the candidate is already in range and this is a no-op.
      cand_eff   = (cand >= IDX_W'(DECK_SIZE)) ? cand - IDX_W'(DECK_SIZE) : cand;
      cand_next  = (cand_eff == IDX_W'(DECK_SIZE - 1)) ? '0 : cand_eff + IDX_W'(1);
      hit        = dealt[cand_eff];

      unique case (state)
         IDLE: begin
            if (shuffle) begin
               // Shuffle wins over same-cycle requests; they are accepted next cycle.
               do_shuffle = 1'b1;
            end else if (!deck_empty) begin
               if (player_req && dealer_req) begin
                  win_player = !last_player;
                  win_dealer = last_player;
               end else begin
                  win_player = player_req;
                  win_dealer = dealer_req;
               end
               if (win_player || win_dealer) begin
                  next_state = FETCH;
               end
            end
         end
         FETCH:   next_state = CHECK;
         CHECK:   if (!hit) next_state = DELIVER;
         DELIVER: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // NOTE: the dealt bitmap is a plain register bank, not a RAM, so it can be
   // cleared by reset and by shuffle in a single cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         cand         <= '0;
         dealt        <= '0;
         dealt_cnt    <= '0;
         last_player  <= 1'b0;   // dealer "served last" so player wins first
         grant_player <= 1'b0;
         grant_dealer <= 1'b0;
         card_valid   <= 1'b0;
         card_index   <= '0;
         card_rank    <= '0;
         card_suit    <= '0;
      end else begin
         card_valid <= 1'b0;

         if (do_shuffle) begin
            dealt     <= '0;
            dealt_cnt <= '0;
         end

         if (win_player) begin
            grant_player <= 1'b1;
            last_player  <= 1'b1;
         end
         if (win_dealer) begin
            grant_dealer <= 1'b1;
            last_player  <= 1'b0;
         end

         if (state == FETCH) begin
            cand <= rand_value;
         end

         if (state == CHECK) begin
            if (hit) begin
               cand <= cand_next;   // linear probe, one card per cycle
            end else begin
               card_valid        <= 1'b1;
               card_index        <= cand_eff;
               card_rank         <= 4'(cand_eff % IDX_W'(13)) + 4'd1;
               card_suit         <= 2'(cand_eff / IDX_W'(13));
               dealt[cand_eff]   <= 1'b1;
               dealt_cnt         <= dealt_cnt + CNT_W'(1);
            end
         end

         if (state == DELIVER) begin
            grant_player <= 1'b0;
            grant_dealer <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_card_draw_arbiter.sv
// -----------------------------------------------------------------------------
// tb_card_draw_arbiter
//
// Self-checking bench for card_draw_arbiter. A deck model (array of dealt
// flags, dealt count, last-served requester) predicts the winner, the dealt
// card, its rank/suit and the delivery latency of each draw.
// -----------------------------------------------------------------------------
module tb_card_draw_arbiter;

   localparam int DECK_SIZE = 52;
   localparam int IDX_W     = 6;

   logic             clk = 1'b0;
   logic             reset;
   logic             player_req;
   logic             dealer_req;
   logic             shuffle;
   logic [IDX_W-1:0] rand_value;
   logic             rand_request;
   logic             grant_player;
   logic             grant_dealer;
   logic             card_valid;
   logic [IDX_W-1:0] card_index;
   logic [3:0]       card_rank;
   logic [1:0]       card_suit;
   logic             deck_empty;
   logic             busy;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit m_dealt [DECK_SIZE];
   int m_cnt;
   bit m_last_player;

   card_draw_arbiter #(
      .DECK_SIZE(DECK_SIZE),
      .IDX_W    (IDX_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .player_req   (player_req),
      .dealer_req   (dealer_req),
      .shuffle      (shuffle),
      .rand_value   (rand_value),
      .rand_request (rand_request),
      .grant_player (grant_player),
      .grant_dealer (grant_dealer),
      .card_valid   (card_valid),
      .card_index   (card_index),
      .card_rank    (card_rank),
      .card_suit    (card_suit),
      .deck_empty   (deck_empty),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      foreach (m_dealt[i]) m_dealt[i] = 1'b0;
      m_cnt = 0;
   endtask

   // One complete draw from IDLE back to IDLE. hold keeps the requests high
   // after acceptance; shuf_mid raises shuffle during the transaction, which
   // the block must ignore.
   task automatic draw(input logic pr, input logic dr, input logic [IDX_W-1:0] rv,
                       input bit hold, input bit shuf_mid);
      bit win_p;
      int c;
      int probes;
      int lat;
      win_p  = (pr && dr) ? !m_last_player : pr;
      c      = int'(rv) % DECK_SIZE;
      probes = 0;
      while (m_dealt[c]) begin
         c = (c + 1) % DECK_SIZE;
         probes++;
      end

      player_req = pr;
      dealer_req = dr;
      rand_value = rv;
      step();   // acceptance edge
      check("grant_player", grant_player, win_p);
      check("grant_dealer", grant_dealer, !win_p);
      check("rand_request", rand_request, 1);
      if (!hold) begin
         player_req = 1'b0;
         dealer_req = 1'b0;
      end
      if (shuf_mid) shuffle = 1'b1;

      lat = 1;
      while (!card_valid && lat < 64) begin
         step();
         lat++;
      end
      shuffle = 1'b0;
      check("latency", lat, 3 + probes);
      check("card_index", card_index, c);
      check("card_rank", card_rank, c % 13 + 1);
      check("card_suit", card_suit, c / 13);
      check("grant_held", {grant_player, grant_dealer}, {win_p, !win_p});

      m_dealt[c]    = 1'b1;
      m_cnt++;
      m_last_player = win_p;

      step();   // back in IDLE
      check("valid_pulse", card_valid, 0);
      check("busy_idle", busy, 0);
      check("grant_clear", {grant_player, grant_dealer}, 0);
      check("deck_empty", deck_empty, m_cnt == DECK_SIZE);
   endtask

   initial begin
      bit seen_valid;
      reset      = 1'b1;
      player_req = 1'b1;
      dealer_req = 1'b0;
      shuffle    = 1'b0;
      rand_value = '0;
      model_clear();
      m_last_player = 1'b0;
      repeat (3) step();

      // Reset state: everything low, even with a request pending.
      check("rst_outputs", {rand_request, grant_player, grant_dealer, card_valid,
                            card_index, card_rank, card_suit, deck_empty, busy}, 0);
      reset      = 1'b0;
      player_req = 1'b0;

      // First draw: rand 5 -> card 5, rank 6, suit 0, 3 cycles.
      draw(1'b1, 1'b0, 6'd5, 1'b0, 1'b0);
      // Collision: rand 5 again -> card 6, 4 cycles.
      draw(1'b0, 1'b1, 6'd5, 1'b0, 1'b0);

      // Shuffle beats a same-cycle request, which is accepted next cycle.
      shuffle    = 1'b1;
      player_req = 1'b1;
      step();
      check("shuffle_no_grant", {grant_player, grant_dealer, busy}, 0);
      shuffle = 1'b0;
      model_clear();
      // Fresh deck: rand 60 -> card 8, rank 9, suit 0.
      draw(1'b1, 1'b0, 6'd60, 1'b0, 1'b0);

      // Reset during CHECK: rand 8 collides with card 8, so CHECK lasts 2 cycles.
      player_req = 1'b1;
      rand_value = 6'd8;
      step();   // FETCH
      player_req = 1'b0;
      step();   // first CHECK
      check("in_check_busy", busy, 1);
      reset = 1'b1;
      step();
      check("rst_mid_busy", busy, 0);
      check("rst_mid_grant", {grant_player, grant_dealer, card_valid}, 0);
      reset = 1'b0;
      seen_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (card_valid) seen_valid = 1'b1;
      end
      check("rst_no_valid", seen_valid, 0);
      model_clear();
      m_last_player = 1'b0;

      // Both requesting: player first after reset, then alternating. The first
      // draw of card 8 in 3 cycles also shows the bitmap was cleared.
      draw(1'b1, 1'b1, 6'd8, 1'b1, 1'b0);
      draw(1'b1, 1'b1, 6'd8, 1'b1, 1'b0);
      draw(1'b1, 1'b1, 6'd51, 1'b1, 1'b0);
      draw(1'b1, 1'b1, 6'd63, 1'b0, 1'b0);

      // Randomised fill of the rest of the deck.
      while (m_cnt < DECK_SIZE) begin
         logic pr;
         logic dr;
         pr = 1'($urandom_range(0, 1));
         dr = pr ? 1'($urandom_range(0, 1)) : 1'b1;
         draw(pr, dr, IDX_W'($urandom_range(0, 63)), 1'b0, (m_cnt % 10) == 7);
      end

      // Empty deck: requests are ignored.
      check("deck_empty_full", deck_empty, 1);
      player_req = 1'b1;
      dealer_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("empty_no_grant", {grant_player, grant_dealer, busy}, 0);
      end
      dealer_req = 1'b0;

      // Shuffle restores the deck; the held player request is served next.
      shuffle = 1'b1;
      step();
      shuffle = 1'b0;
      check("shuffle_refill", deck_empty, 0);
      model_clear();
      draw(1'b1, 1'b0, IDX_W'($urandom_range(0, 63)), 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/card_draw_arbiter.md
CARD_DRAW_ARBITER -- requirements
Module: card_draw_arbiter

Interface
REQ-001 The block SHALL have parameter DECK_SIZE, default 52, meaning the number of distinct cards per deck.
REQ-002 The block SHALL have parameter IDX_W, default 6, meaning the width of the card index and of the random-value input.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port player_req, input, 1 bit: level request for one card by the player.
REQ-006 The block SHALL have port dealer_req, input, 1 bit: level request for one card by the dealer.
REQ-007 The block SHALL have port shuffle, input, 1 bit: return all cards to the deck.
REQ-008 The block SHALL have port rand_value, input, IDX_W bits: the value from the random number generator, valid while rand_request is high.
REQ-009 The block SHALL have port rand_request, output, 1 bit: requests and samples a random value.
REQ-010 The block SHALL have ports grant_player and grant_dealer, output, 1 bit each: the requester currently being served.
REQ-011 The block SHALL have port card_valid, output, 1 bit: one-cycle card delivery strobe.
REQ-012 The block SHALL have port card_index, output, IDX_W bits: the dealt card, 0..DECK_SIZE-1.
REQ-013 The block SHALL have port card_rank, output, 4 bits: the card rank, 1..13 (1 = ace).
REQ-014 The block SHALL have port card_suit, output, 2 bits: the card suit, 0..3.
REQ-015 The block SHALL have port deck_empty, output, 1 bit: high when all DECK_SIZE cards have been dealt.
REQ-016 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-017 The FSM SHALL have four states, IDLE, FETCH, CHECK and DELIVER, with these transitions:
- IDLE -> FETCH on an accepted request.
- FETCH -> CHECK always.
- CHECK -> CHECK on a collision.
- CHECK -> DELIVER on a free card.
- DELIVER -> IDLE always.
REQ-018 Acceptance in IDLE SHALL be round-robin:
- A single requester wins.
- On simultaneous requests, the requester not served last wins.
- The pointer updates on each grant.
REQ-019 The grant for the winner SHALL be set on leaving IDLE and held through DELIVER; it clears on return to IDLE.
REQ-020 In FETCH, rand_request SHALL be 1 for exactly one cycle, and rand_value SHALL be captured as candidate in that same cycle.
REQ-021 In the first CHECK cycle, a candidate >= DECK_SIZE SHALL be reduced by DECK_SIZE (e.g. 60 -> 8).
REQ-022 In CHECK, if the candidate is already marked dealt, the candidate SHALL advance by 1, wrapping DECK_SIZE-1 -> 0; each probe takes one cycle.
REQ-023 On entering DELIVER, the block SHALL:
- register card_index = candidate, card_rank = candidate mod 13 + 1, card_suit = candidate / 13;
- set the dealt bit for the candidate;
- increment the dealt count.
REQ-024 card_valid SHALL be 1 only in the DELIVER cycle; card_index, card_rank and card_suit SHALL hold their values until the next delivery.
REQ-025 Minimum latency SHALL be 3 cycles: request accepted at edge N gives card_valid at N+3; each collision probe adds 1 cycle.
REQ-026 deck_empty SHALL be 1 when the dealt count equals DECK_SIZE; requests in IDLE while deck_empty is 1 SHALL be ignored, with no grant.
REQ-027 shuffle SHALL be honoured only in IDLE:
- it clears the dealt bitmap and count in one cycle;
- it takes priority over same-cycle requests, which are accepted the following cycle;
- shuffle outside IDLE is ignored.
REQ-028 A requester still holding its request after its card_valid SHALL be eligible again subject to round-robin; dropping a request mid-transaction SHALL NOT abort delivery.

Reset
REQ-029 On reset=1 at a clock edge, the block SHALL:
- set the state to IDLE and clear the bitmap and dealt count;
- set the round-robin pointer to favour player;
- drive all outputs to 0 (deck_empty = 0).
REQ-030 Reset SHALL take effect from any state, including mid-CHECK, with no card_valid produced for the aborted transaction.

Verification
REQ-031 After reset, player_req=1 and rand_value=5 -> grant_player=1, then card_valid at N+3 with card_index=5, rank=6, suit=0.
REQ-032 player_req and dealer_req both held -> player served first, dealer second, alternating thereafter.
REQ-033 rand_value=60 on a fresh deck -> card_index=8, rank=9, suit=0.
REQ-034 Card 5 dealt, then rand_value=5 -> card_index=6, card_valid at N+4.
REQ-035 52 deliveries -> deck_empty=1 and a further request gets no grant; shuffle in IDLE -> deck_empty=0, and the next draw succeeds.
REQ-036 reset asserted during CHECK -> IDLE next cycle, busy=0, card_valid never asserted, bitmap cleared.
